// File: rtl/layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | layer_sequencer                                                            |
// | Layer controller for conv1 -> max-pool -> fire squeeze. It drives the      |
// | stage enables and the bank write addresses, and has a start/done handshake.|
// | Optional macro FIRE_LOOP_EN repeats the squeeze stage for NUM_FIRE passes. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module layer_sequencer #(
    parameter int CONV1_OUT = 12321,
    parameter int POOL_OUT  = 3025,
    parameter int SQ_OUT    = 3025,
    parameter int NUM_FIRE  = 8,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              conv1_valid,
    input  logic              pool_valid,
    input  logic              sq_valid,
    output logic              conv_en,
    output logic              pool_en,
    output logic              sq_en,
    output logic [ADDR_W-1:0] conv_waddr,
    output logic [ADDR_W-1:0] pool_waddr,
    output logic [ADDR_W-1:0] sq_waddr,
    output logic [2:0]        firesel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_POOL = 3'd2,
        S_SQZ  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // A limit of 0 or 1 ends the stage on its first strobe.
    localparam logic [ADDR_W-1:0] c_CONV_LAST = ADDR_W'((CONV1_OUT > 1) ? CONV1_OUT - 1 : 0);
    localparam logic [ADDR_W-1:0] c_POOL_LAST = ADDR_W'((POOL_OUT  > 1) ? POOL_OUT  - 1 : 0);
    localparam logic [ADDR_W-1:0] c_SQ_LAST   = ADDR_W'((SQ_OUT    > 1) ? SQ_OUT    - 1 : 0);
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);
`ifdef FIRE_LOOP_EN
    localparam logic [2:0] c_FIRE_LAST = (NUM_FIRE > 8) ? 3'd7 :
                                         (NUM_FIRE < 2) ? 3'd0 : 3'(NUM_FIRE - 1);
`endif

    state_t            state_q;
    logic              conv_en_q;
    logic              pool_en_q;
    logic              sq_en_q;
    logic [ADDR_W-1:0] conv_waddr_q;
    logic [ADDR_W-1:0] pool_waddr_q;
    logic [ADDR_W-1:0] sq_waddr_q;
    logic [2:0]        firesel_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              w_stray;

    // Any strobe that does not belong to the stage currently running.
    always_comb begin
        w_stray = 1'b0;
        case (state_q)
            S_CONV:  w_stray = pool_valid  | sq_valid;
            S_POOL:  w_stray = conv1_valid | sq_valid;
            S_SQZ:   w_stray = conv1_valid | pool_valid;
            default: w_stray = conv1_valid | pool_valid | sq_valid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            conv_en_q    <= 1'b0;
            pool_en_q    <= 1'b0;
            sq_en_q      <= 1'b0;
            conv_waddr_q <= '0;
            pool_waddr_q <= '0;
            sq_waddr_q   <= '0;
            firesel_q    <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (w_stray) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_CONV;
                        conv_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (conv1_valid) begin
                        if (conv_waddr_q == c_CONV_LAST) begin
                            state_q      <= S_POOL;
                            conv_waddr_q <= '0;
                            conv_en_q    <= 1'b0;
                            pool_en_q    <= 1'b1;
                        end else begin
                            conv_waddr_q <= conv_waddr_q + c_ONE;
                        end
                    end
                end
                S_POOL: begin
                    if (pool_valid) begin
                        if (pool_waddr_q == c_POOL_LAST) begin
                            state_q      <= S_SQZ;
                            pool_waddr_q <= '0;
                            pool_en_q    <= 1'b0;
                            sq_en_q      <= 1'b1;
                        end else begin
                            pool_waddr_q <= pool_waddr_q + c_ONE;
                        end
                    end
                end
                S_SQZ: begin
                    if (sq_valid) begin
                        if (sq_waddr_q == c_SQ_LAST) begin
                            sq_waddr_q <= '0;
`ifdef FIRE_LOOP_EN
                            if (firesel_q != c_FIRE_LAST) begin
                                firesel_q <= firesel_q + 3'd1;
                            end else begin
                                state_q   <= S_FIN;
                                sq_en_q   <= 1'b0;
                                done_q    <= 1'b1;
                                firesel_q <= 3'd0;
                            end
`else
                            state_q <= S_FIN;
                            sq_en_q <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            sq_waddr_q <= sq_waddr_q + c_ONE;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign conv_en    = conv_en_q;
    assign pool_en    = pool_en_q;
    assign sq_en      = sq_en_q;
    assign conv_waddr = conv_waddr_q;
    assign pool_waddr = pool_waddr_q;
    assign sq_waddr   = sq_waddr_q;
    assign firesel    = firesel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_layer_sequencer                                                         |
// | Vector table, directed corner sequences and random traffic vs. a model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_layer_sequencer;

    localparam int C  = 4;
    localparam int PL = 2;
    localparam int S  = 3;
    localparam int NF = 2;
`ifdef FIRE_LOOP_EN
    localparam int PASSES = NF;
`else
    localparam int PASSES = 1;
`endif
    localparam int TOTAL = C + PL + S * PASSES;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cv = 1'b0;
    logic        pv = 1'b0;
    logic        sv = 1'b0;
    logic        conv_en, pool_en, sq_en, busy, done, err;
    logic [31:0] conv_waddr, pool_waddr, sq_waddr;
    logic [2:0]  firesel;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .CONV1_OUT(C), .POOL_OUT(PL), .SQ_OUT(S), .NUM_FIRE(NF), .ADDR_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .conv1_valid(cv), .pool_valid(pv), .sq_valid(sv),
        .conv_en(conv_en), .pool_en(pool_en), .sq_en(sq_en),
        .conv_waddr(conv_waddr), .pool_waddr(pool_waddr), .sq_waddr(sq_waddr),
        .firesel(firesel), .busy(busy), .done(done), .err(err)
    );

    // Reference model: progress is the number of accepted strobes in the run;
    // stage, addresses and fire pass all follow arithmetically from it.
    int m_p   = 0;
    bit m_run = 1'b0;
    bit m_fin = 1'b0;
    bit m_err = 1'b0;

    function automatic int stage_of(int p);
        if (p < C) return 0;
        if (p < C + PL) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin : model
        bit [2:0] strb;
        int       cur;
        strb = {sv, pv, cv};
        if (!rst) begin
            m_run = 1'b0; m_fin = 1'b0; m_p = 0; m_err = 1'b0;
        end else if (m_fin) begin
            if (strb != 3'b000) m_err = 1'b1;
            m_fin = 1'b0;
        end else if (!m_run) begin
            if (strb != 3'b000) m_err = 1'b1;
            if (start) begin
                m_run = 1'b1; m_p = 0;
            end
        end else begin
            cur = stage_of(m_p);
            if ((strb & ~(3'b001 << cur)) != 3'b000) m_err = 1'b1;
            if (strb[cur]) begin
                m_p++;
                if (m_p == TOTAL) begin
                    m_run = 1'b0; m_fin = 1'b1; m_p = 0;
                end
            end
        end
    end

    function automatic logic [104:0] expv();
        logic        ce, pe, se;
        logic [31:0] cw, pw, sw;
        logic [2:0]  fs;
        int          st;
        ce = 1'b0; pe = 1'b0; se = 1'b0;
        cw = '0; pw = '0; sw = '0; fs = '0;
        st = m_run ? stage_of(m_p) : 3;
        if (st == 0) begin ce = 1'b1; cw = 32'(m_p); end
        if (st == 1) begin pe = 1'b1; pw = 32'(m_p - C); end
        if (st == 2) begin
            se = 1'b1;
            sw = 32'((m_p - C - PL) % S);
            fs = 3'((m_p - C - PL) / S);
        end
        return {ce, pe, se, cw, pw, sw, fs, m_run | m_fin, m_fin, m_err};
    endfunction

    wire [104:0] dut_v = {conv_en, pool_en, sq_en, conv_waddr, pool_waddr, sq_waddr,
                          firesel, busy, done, err};

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (dut_v !== expv()) begin
                n_err++;
                $display("FAIL model t=%0t got %h expected %h", $time, dut_v, expv());
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic c, input logic p, input logic q);
        @(negedge clk);
        rst = r; start = s; cv = c; pv = p; sv = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit r, s, c, p, q;
        bit ce, pe, se;
        int cw, pw, sw, fs;
        bit b, d, e;
    } vec_t;

    function automatic vec_t V(bit r, bit s, bit c, bit p, bit q, bit ce, bit pe, bit se,
                               int cw, int pw, int sw, int fs, bit b, bit d, bit e);
        vec_t t;
        t.r = r; t.s = s; t.c = c; t.p = p; t.q = q;
        t.ce = ce; t.pe = pe; t.se = se;
        t.cw = cw; t.pw = pw; t.sw = sw; t.fs = fs;
        t.b = b; t.d = d; t.e = e;
        return t;
    endfunction

    vec_t tbl[$];

    task automatic run_sq(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1);
    endtask

    initial begin
        //          r s c p q  ce pe se cw pw sw fs  b d e
        tbl.push_back(V(0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(V(1,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(V(1,1,0,0,0, 1,0,0, 0,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,1,0,0, 1,0,0, 1,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,0,0,0, 1,0,0, 1,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,1,0,0, 1,0,0, 2,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,1,0,0, 1,0,0, 3,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,1,0,0, 0,1,0, 0,0,0,0, 1,0,0));
        tbl.push_back(V(1,1,0,0,0, 0,1,0, 0,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,0,1,0, 0,1,0, 0,1,0,0, 1,0,0));
        tbl.push_back(V(1,0,0,1,0, 0,0,1, 0,0,0,0, 1,0,0));
        tbl.push_back(V(1,0,0,0,1, 0,0,1, 0,0,1,0, 1,0,0));
        tbl.push_back(V(1,0,0,0,1, 0,0,1, 0,0,2,0, 1,0,0));
`ifdef FIRE_LOOP_EN
        tbl.push_back(V(1,0,0,0,1, 0,0,1, 0,0,0,1, 1,0,0));
        tbl.push_back(V(1,0,0,0,1, 0,0,1, 0,0,1,1, 1,0,0));
        tbl.push_back(V(1,0,0,0,1, 0,0,1, 0,0,2,1, 1,0,0));
`endif
        tbl.push_back(V(1,0,0,0,1, 0,0,0, 0,0,0,0, 1,1,0));
        tbl.push_back(V(1,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].p, tbl[i].q);
            chk_en = 1'b1;
            chk($sformatf("tbl%0d.en", i), {29'd0, conv_en, pool_en, sq_en},
                {29'd0, tbl[i].ce, tbl[i].pe, tbl[i].se});
            chk($sformatf("tbl%0d.cw", i), conv_waddr, 32'(tbl[i].cw));
            chk($sformatf("tbl%0d.pw", i), pool_waddr, 32'(tbl[i].pw));
            chk($sformatf("tbl%0d.sw", i), sq_waddr, 32'(tbl[i].sw));
            chk($sformatf("tbl%0d.fs", i), {29'd0, firesel}, 32'(tbl[i].fs));
            chk($sformatf("tbl%0d.bde", i), {29'd0, busy, done, err},
                {29'd0, tbl[i].b, tbl[i].d, tbl[i].e});
        end

        // Stray pool strobe during conv: ignored, sticky error until reset.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("stray.cw", conv_waddr, 32'd1);
        chk("stray.err", {31'd0, err}, 32'd1);
        for (int i = 0; i < C - 1; i++) cyc(1, 0, 1, 0, 0);
        chk("stray.pool_en", {31'd0, pool_en}, 32'd1);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        run_sq(S * PASSES);
        chk("stray.done", {30'd0, done, err}, 32'd3);
        cyc(0, 0, 0, 0, 0);
        chk("stray.clr", {31'd0, err}, 32'd0);

        // Reset mid-layer, then a clean restart from address 0.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("midrst.cw2", conv_waddr, 32'd2);
        cyc(0, 0, 0, 0, 0);
        chk("midrst.idle", {29'd0, conv_en, busy, err}, 32'd0);
        chk("midrst.cw", conv_waddr, 32'd0);
        cyc(1, 1, 0, 0, 0);
        chk("restart.en", {30'd0, conv_en, busy}, 32'd3);
        cyc(1, 0, 1, 0, 0);
        chk("restart.cw", conv_waddr, 32'd1);

        // Final conv strobe together with a pool strobe.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0);
        chk("simul.pe", {30'd0, conv_en, pool_en}, 32'd1);
        chk("simul.pw", pool_waddr, 32'd0);
        chk("simul.err", {31'd0, err}, 32'd1);

        // Random traffic, biased toward the strobe of the running stage.
        cyc(0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            int  st;
            bit  own;
            st  = m_run ? stage_of(m_p) : 3;
            own = ($urandom_range(0, 1) == 1);
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) == 0),
                (st == 0 && own) || ($urandom_range(0, 39) == 0),
                (st == 1 && own) || ($urandom_range(0, 39) == 0),
                (st == 2 && own) || ($urandom_range(0, 39) == 0));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
# layer_sequencer

Layer-level controller for the image front end: conv1 → 2×2 max-pool → fire squeeze 1×1. Replaces free-running enables and per-layer output counters with one FSM. The FSM:
- drives each stage's input-valid enable;
- counts that stage's output-valid strobes to produce bank write addresses (pool banks, ping-pong memory, squeeze/expand bank);
- advances to the next layer when the programmed output count is reached.

It sits between the stage instances and the top level and exposes a single start/done handshake.

## Interface
Parameters:
- CONV1_OUT, 12321: conv1 output pixels (111×111).
- POOL_OUT, 3025: max-pool output pixels (55×55).
- SQ_OUT, 3025: squeeze output pixels per fire pass.
- NUM_FIRE, 8: fire passes when FIRE_LOOP_EN is defined (1..8).
- ADDR_W, 32: address and counter width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run the full sequence.
- conv1_valid  in  1  conv1 output-valid strobe.
- pool_valid  in  1  max-pool output-valid strobe.
- sq_valid  in  1  squeeze output-valid strobe.
- conv_en  out  1  conv1 input-valid / pool-bank write enable.
- pool_en  out  1  max-pool input-valid / pool-bank read enable.
- sq_en  out  1  squeeze input-valid / ping-pong read enable.
- conv_waddr  out  ADDR_W  pool-bank write address.
- pool_waddr  out  ADDR_W  ping-pong write address.
- sq_waddr  out  ADDR_W  squeeze/expand bank write address.
- firesel  out  3  fire-module select for the squeeze weight ROM.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  sticky; set by any strobe arriving outside its own stage.

## Operation
- States: IDLE, CONV, POOL, SQZ, FIN.
- Reset (rst=0 at an edge) forces IDLE. All outputs and counters go to 0, including err. This applies in any state, including mid-layer.
- IDLE → CONV on start=1. start is ignored in every other state.
- CONV:
  - conv_en=1.
  - Each conv1_valid increments conv_waddr after use. The address presented with strobe k (k from 0) is k.
  - On the strobe where conv_waddr == CONV1_OUT-1: go to POOL and clear conv_waddr.
- POOL: same rule with pool_en, pool_valid, pool_waddr and POOL_OUT. Last strobe → SQZ.
- SQZ: same rule with sq_en, sq_valid, sq_waddr and SQ_OUT. Last strobe → FIN, or to the next fire pass (see Configuration).
- FIN: done=1 for exactly one cycle, then IDLE. All enables are 0 in FIN.
- Exactly one of conv_en/pool_en/sq_en is high at a time.
- Strobe in the wrong state (e.g. conv1_valid in POOL or IDLE):
  - the strobe is ignored;
  - counters are unchanged;
  - err←1, held until reset.
- Simultaneous strobes: only the current stage's strobe is counted. Every other asserted strobe sets err.
- Counters compare with ==. A parameter of 0 or 1 must still terminate: a value of 1 transitions on the first strobe. A counter never wraps past its limit.

## Timing
- All outputs are registered.
- start sampled at edge N → busy=1, conv_en=1 from edge N.
- Stage changes: final strobe sampled at edge N → new enable high after edge N. The old enable drops in the same cycle; no overlap, no gap.
- Address timing: conv_waddr holds k during the cycle strobe k is presented. It updates to k+1 at that edge.
- done: pulses in the cycle after the final sq_valid edge. busy falls with done's falling edge, i.e. one cycle after FIN.
- Latency, start to done: the sum of the stage latencies plus 2 cycles (IDLE exit, FIN).

## Configuration
- FIRE_LOOP_EN defined:
  - After the last SQZ strobe, if firesel < NUM_FIRE-1: firesel increments, sq_waddr clears, and the FSM stays in SQZ with sq_en held high.
  - Otherwise → FIN.
  - firesel returns to 0 in IDLE.
- FIRE_LOOP_EN undefined:
  - firesel is constant 0.
  - A single squeeze pass, then FIN.
  - NUM_FIRE is unused.

## Test plan
Parameters for all tests: CONV1_OUT=4, POOL_OUT=2, SQ_OUT=3, NUM_FIRE=2.

1. Reset, then start, then strobes:
   - 4 conv1_valid → conv_waddr 0,1,2,3 presented, then pool_en=1.
   - 2 pool_valid → sq_en=1.
   - 3 sq_valid → done=1 for one cycle, then busy=0 and all addresses 0.
2. start pulsed again during POOL → no effect. Sequence completes with one done pulse.
3. pool_valid asserted in CONV → conv_waddr unchanged, err=1 and it stays 1 through the run. rst=0 clears it.
4. rst=0 after 2 conv1_valid → next cycle state IDLE, conv_en=0, conv_waddr=0. A new start restarts from address 0.
5. conv1_valid and pool_valid on the final CONV strobe → transition to POOL, pool_waddr=0 (pool strobe not counted), err=1.
6. FIRE_LOOP_EN defined, 6 sq_valid → firesel 0 for strobes 0–2 and 1 for strobes 3–5, sq_waddr 0,1,2,0,1,2, done after the sixth. Undefined: done after the third, firesel always 0.
